mic_measure_scheduler: RTL and testbench
========================================

# mic_measure_scheduler

Round-robin measurement sequencer that shares one HzCounter between several microphone comparator inputs. It routes one mic at a time to the counter, generates the counter's gate window, captures the resulting frequency, and keeps a per-channel result bank with valid flags. It sits between the mic input pins (JA-header signals) and the steering logic that consumes per-mic frequencies.

## Interface
- `N_MIC`, 3: number of mic channels, 2..4.
- `HZ_W`, 10: width of the frequency result, matching the counter output.
- `GATE_CYCLES`, 100_000_000: gate-high length in clk cycles (1 s at 100 MHz).
- `SETTLE_CYCLES`, 16: cycles after a channel switch before the gate opens.
- `CAPTURE_DELAY`, 2: cycles after the gate falls before `hz_in` is sampled.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: run the scheduler; low aborts and idles.
- `mic_in` in N_MIC: raw mic comparator signals.
- `mic_out` out 1: selected mic, registered, to the counter's signal input.
- `gate` out 1: counter window, the OneSecond equivalent.
- `hz_in` in HZ_W: counter result.
- `sel` out 2: channel currently being measured.
- `hz_out` out N_MIC*HZ_W: result bank; channel i occupies bits [i*HZ_W +: HZ_W].
- `valid` out N_MIC: channel i holds at least one completed result.
- `sample_done` out 1: one-cycle pulse when a result is latched.
- `best_ch` out 2, `best_valid` out 1: loudest channel. These are feature-gated; see Configuration.

## Operation
- States: IDLE, SETTLE, GATE, CAPTURE, NEXT.
- IDLE:
  - `gate`=0, `mic_out`=0, `sel` holds its value.
  - On `enable`=1, go to SETTLE with `sel`=0.
- SETTLE:
  - `mic_out` follows `mic_in[sel]` through one register.
  - After SETTLE_CYCLES cycles, go to GATE.
- GATE:
  - `gate`=1 for exactly GATE_CYCLES cycles, then go to CAPTURE.
- CAPTURE:
  - `gate`=0 for CAPTURE_DELAY cycles.
  - On the last cycle's edge, `hz_out[sel]`<=`hz_in`, `valid[sel]`<=1, and `sample_done`=1 for one cycle.
  - Then go to NEXT.
- NEXT (one cycle):
  - `sel`<=`sel`+1; it wraps from N_MIC-1 to 0.
  - Then go to SETTLE.
- `enable` low in any non-IDLE state:
  - Go to IDLE on the next edge; `gate` drops that edge.
  - No capture occurs; `hz_out` and `valid` are retained.
  - The next enable restarts at channel 0.
- `enable` and the capture edge in the same cycle: the capture completes, then the block idles.
- `hz_in` is stored unmodified; there is no width conversion.

## Timing
- Reset values:
  - Outputs: `gate`=0, `mic_out`=0, `sel`=0, `hz_out`=0, `valid`=0, `sample_done`=0, `best_ch`=0, `best_valid`=0.
  - State: IDLE.
- `reset` overrides everything, including mid-gate: the gate drops on the reset edge.
- Per-channel period: SETTLE_CYCLES+GATE_CYCLES+CAPTURE_DELAY+1 cycles.
- The first `gate` high is SETTLE_CYCLES+1 edges after `enable` is sampled high.
- `mic_out` lags `mic_in[sel]` by one cycle.
- `sample_done` coincides with the edge on which `hz_out`/`valid` update.

## Configuration
- `MIC_SCHED_BEST_EN` defined:
  - `best_ch` is the index of the largest `hz_out` among valid channels; ties go to the lowest index.
  - `best_valid` = OR of `valid`.
  - Both are registered and update the cycle after `sample_done`.
- `MIC_SCHED_BEST_EN` undefined: `best_ch`=0 and `best_valid`=0 constant; no comparator logic.

## Structure
- Package `mic_pkg`:
  - State enum `mic_sched_state_t`.
  - Default constants `MIC_HZ_W`=10 and `MIC_N`=3.
- Sub-module `phase_timer`:
  - Loadable down-counter with a `done` flag.
  - Reused for the settle, gate and capture phases, sized to `$clog2(GATE_CYCLES+1)`.

## Test plan
- Use GATE_CYCLES=20, SETTLE_CYCLES=4, CAPTURE_DELAY=2. The bench model drives `hz_in`=100+10*`sel` during CAPTURE.
1. Reset, then `enable`=1 → `gate` rises 5 edges later and stays high exactly 20 cycles; `sample_done` pulses 2 cycles after the gate falls; `hz_out[0]`=100, `valid`=001.
2. Run three full periods → `hz_out`={120,110,100}, `valid`=111, `sel` returns to 0; period = 27 cycles.
3. Drop `enable` mid-GATE of channel 1 → `gate`=0 the next cycle, no `sample_done`, `valid`=001 retained; re-enable restarts at `sel`=0.
4. Assert `reset` mid-GATE → all outputs at reset values on that edge, `valid`=0.
5. Toggle `mic_in[1]` only, with `sel`=1 → `mic_out` equals the toggle delayed one cycle; with `sel`=0, `mic_out` stays 0.
6. With `MIC_SCHED_BEST_EN`, results {100,130,130} → `best_ch`=1 and `best_valid`=1. Without the macro → both stay 0.

Source files
------------

// File: rtl/mic_measure_scheduler_pkg.sv
// Shared types and defaults for the mic measurement scheduler.
package mic_pkg;

    localparam int MIC_HZ_W = 10;
    localparam int MIC_N    = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_GATE    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4
    } mic_sched_state_t;

    function automatic logic [1:0] mic_next_sel(input logic [1:0] sel, input int n_mic);
        logic [1:0] nxt;
        if (sel == 2'(n_mic - 1)) begin
            nxt = 2'd0;
        end else begin
            nxt = sel + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mic_measure_scheduler_phase_timer.sv
// Loadable down-counter; o_done is high once the loaded count has run out.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_count;
    logic         r_done;

    // Count down from the loaded value; done is registered one step ahead of zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= W'(0);
            r_done  <= 1'b1;
        end else if (i_load) begin
            r_count <= i_value;
            r_done  <= (i_value == W'(0));
        end else if (r_count != W'(0)) begin
            r_count <= r_count - W'(1);
            r_done  <= (r_count == W'(1));
        end else begin
            r_done  <= 1'b1;
        end
    end

    assign o_done = r_done;

endmodule

// File: rtl/mic_measure_scheduler.sv
// Round-robin mic frequency sequencer sharing one Hz counter.
// Optional loudest-channel tracker enabled by MIC_SCHED_BEST_EN.
module mic_measure_scheduler
    import mic_pkg::*;
#(
    parameter int N_MIC         = MIC_N,
    parameter int HZ_W          = MIC_HZ_W,
    parameter int GATE_CYCLES   = 100_000_000,
    parameter int SETTLE_CYCLES = 16,
    parameter int CAPTURE_DELAY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N_MIC-1:0]       mic_in,
    output logic                   mic_out,
    output logic                   gate,
    input  logic [HZ_W-1:0]        hz_in,
    output logic [1:0]             sel,
    output logic [N_MIC*HZ_W-1:0]  hz_out,
    output logic [N_MIC-1:0]       valid,
    output logic                   sample_done,
    output logic [1:0]             best_ch,
    output logic                   best_valid
);

    localparam int TW = $clog2(GATE_CYCLES + 1);

    mic_sched_state_t      r_state;
    mic_sched_state_t      w_state_nxt;
    logic [1:0]            r_sel;
    logic [1:0]            w_sel_nxt;
    logic                  w_capture;
    logic                  w_load;
    logic [TW-1:0]         w_load_val;
    logic                  w_done;
    logic                  r_gate;
    logic                  r_mic_out;
    logic                  r_sample_done;
    logic [N_MIC*HZ_W-1:0] r_hz_bank;
    logic [N_MIC-1:0]      r_valid;
    logic [3:0]            w_mic_pad;

    assign w_mic_pad = 4'(mic_in);

    phase_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_done  (w_done)
    );

    // Phase sequencing; a start from idle settles one cycle longer than a channel hop.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        w_load_val  = TW'(0);
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_SETTLE;
                    w_sel_nxt   = 2'd0;
                    w_load      = 1'b1;
                    w_load_val  = TW'(SETTLE_CYCLES);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_done) begin
                    w_state_nxt = ST_GATE;
                    w_load      = 1'b1;
                    w_load_val  = TW'(GATE_CYCLES - 1);
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_GATE: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_done) begin
                    w_state_nxt = ST_CAPTURE;
                    w_load      = 1'b1;
                    w_load_val  = TW'(CAPTURE_DELAY - 1);
                end else begin
                    w_state_nxt = ST_GATE;
                end
            end
            ST_CAPTURE: begin
                // The capture edge wins over a simultaneous disable.
                if (w_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = enable ? ST_NEXT : ST_IDLE;
                end else if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_NEXT: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_sel_nxt   = mic_next_sel(r_sel, N_MIC);
                    w_load      = 1'b1;
                    w_load_val  = TW'(SETTLE_CYCLES - 1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with outputs registered against the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_sel         <= 2'd0;
            r_gate        <= 1'b0;
            r_mic_out     <= 1'b0;
            r_sample_done <= 1'b0;
            r_hz_bank     <= '0;
            r_valid       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_gate        <= (w_state_nxt == ST_GATE);
            r_mic_out     <= (w_state_nxt == ST_IDLE) ? 1'b0 : w_mic_pad[w_sel_nxt];
            r_sample_done <= w_capture;
            for (int i = 0; i < N_MIC; i++) begin
                if (w_capture && (r_sel == 2'(i))) begin
                    r_hz_bank[i*HZ_W +: HZ_W] <= hz_in;
                    r_valid[i]                <= 1'b1;
                end
            end
        end
    end

    assign mic_out     = r_mic_out;
    assign gate        = r_gate;
    assign sel         = r_sel;
    assign hz_out      = r_hz_bank;
    assign valid       = r_valid;
    assign sample_done = r_sample_done;

`ifdef MIC_SCHED_BEST_EN
    logic [1:0]      r_best_ch;
    logic            r_best_valid;
    logic [1:0]      w_best_ch;
    logic [HZ_W-1:0] w_best_hz;
    logic            w_best_any;

    // Strict greater-than keeps ties on the lowest index.
    always_comb begin
        w_best_ch  = 2'd0;
        w_best_hz  = HZ_W'(0);
        w_best_any = 1'b0;
        for (int i = 0; i < N_MIC; i++) begin
            if (r_valid[i] && (!w_best_any || (r_hz_bank[i*HZ_W +: HZ_W] > w_best_hz))) begin
                w_best_ch  = 2'(i);
                w_best_hz  = r_hz_bank[i*HZ_W +: HZ_W];
                w_best_any = 1'b1;
            end else begin
                w_best_any = w_best_any;
            end
        end
    end

    // Register the winner so it trails the result bank by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_best_ch    <= 2'd0;
            r_best_valid <= 1'b0;
        end else begin
            r_best_ch    <= w_best_ch;
            r_best_valid <= |r_valid;
        end
    end

    assign best_ch    = r_best_ch;
    assign best_valid = r_best_valid;
`else
    assign best_ch    = 2'd0;
    assign best_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mic_measure_scheduler.sv
// Self-checking bench: schedule-arithmetic reference model plus directed literal checks.
module tb_mic_measure_scheduler;

    localparam int N   = 3;
    localparam int HW  = 10;
    localparam int GC  = 20;
    localparam int SC  = 4;
    localparam int CD  = 2;
    localparam int PER = SC + GC + CD + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [N-1:0]    mic_in;
    logic            mic_out;
    logic            gate;
    logic [HW-1:0]   hz_in;
    logic [1:0]      sel;
    logic [N*HW-1:0] hz_out;
    logic [N-1:0]    valid;
    logic            sample_done;
    logic [1:0]      best_ch;
    logic            best_valid;

    always #5 clk = ~clk;

    mic_measure_scheduler #(
        .N_MIC(N), .HZ_W(HW), .GATE_CYCLES(GC), .SETTLE_CYCLES(SC), .CAPTURE_DELAY(CD)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mic_in(mic_in), .mic_out(mic_out),
        .gate(gate), .hz_in(hz_in), .sel(sel), .hz_out(hz_out), .valid(valid),
        .sample_done(sample_done), .best_ch(best_ch), .best_valid(best_valid)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_init = 1'b0;
    bit          m_run = 1'b0;
    int          m_k = 0;
    int          m_sel = 0;
    int          m_hz [N];
    logic [N-1:0] m_valid = '0;
    bit          m_gate = 1'b0;
    bit          m_mic = 1'b0;
    bit          m_done = 1'b0;
    int          m_bc = 0;
    bit          m_bv = 1'b0;
    int          hz_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*HW-1:0] pack_hz();
        logic [N*HW-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < N; i++) begin
            v = m_hz[i];
            r[i*HW +: HW] = v[HW-1:0];
        end
        return r;
    endfunction

    function automatic int best_idx();
        int  b = 0;
        int  bh = 0;
        bit  any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && (!any || m_hz[i] > bh)) begin
                b = i;
                bh = m_hz[i];
                any = 1'b1;
            end
        end
        return b;
    endfunction

    // Reference: edge k after the start edge lies at offset (k-1) mod PER of period (k-1)/PER.
    task automatic model_update();
        int o;
        int p;
        if (reset) begin
            m_init = 1'b1; m_run = 1'b0; m_k = 0; m_sel = 0; m_valid = '0;
            for (int i = 0; i < N; i++) m_hz[i] = 0;
            m_gate = 1'b0; m_mic = 1'b0; m_done = 1'b0; m_bc = 0; m_bv = 1'b0;
        end else if (m_init) begin
`ifdef MIC_SCHED_BEST_EN
            m_bc = best_idx();
            m_bv = |m_valid;
`endif
            m_done = 1'b0;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1'b1; m_k = 0; m_sel = 0;
                end
            end else begin
                m_k++;
                o = (m_k - 1) % PER;
                p = (m_k - 1) / PER;
                if (o == PER - 1) begin
                    m_hz[m_sel] = int'(hz_in);
                    m_valid[m_sel] = 1'b1;
                    m_done = 1'b1;
                end
                if (!enable) m_run = 1'b0;
                else m_sel = p % N;
            end
            m_gate = m_run && (m_k > 0) && (((m_k - 1) % PER) >= SC) && (((m_k - 1) % PER) < SC + GC);
            m_mic = m_run ? mic_in[m_sel] : 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        case (hz_mode)
            0:       hz_in = HW'($urandom);
            1:       hz_in = HW'(100 + 10 * m_sel);
            default: hz_in = (m_sel == 0) ? 10'd100 : 10'd130;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // Compare every output against the model once per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("gate", 64'(gate), 64'(m_gate));
                chk("mic_out", 64'(mic_out), 64'(m_mic));
                chk("sel", 64'(sel), 64'(m_sel));
                chk("hz_out", 64'(hz_out), 64'(pack_hz()));
                chk("valid", 64'(valid), 64'(m_valid));
                chk("sample_done", 64'(sample_done), 64'(m_done));
                chk("best_ch", 64'(best_ch), 64'(m_bc));
                chk("best_valid", 64'(best_valid), 64'(m_bv));
            end
        end
    end

    initial begin
        int rise0, fall0, done0, rise1, dn;
        logic prev;
        reset = 1'b1; enable = 1'b0; mic_in = '0; hz_in = '0;
        tick(); tick();
        chk("rst_gate", 64'(gate), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_hz", 64'(hz_out), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_done", 64'(sample_done), 64'd0);
        reset = 1'b0; hz_mode = 1;
        tick();

        // Start timing, first capture and three full periods.
        enable = 1'b1;
        rise0 = -1; fall0 = -1; done0 = -1; rise1 = -1;
        for (int e = 0; e <= 3 * PER + 1; e++) begin
            tick();
            if (rise1 < 0 && fall0 >= 0 && gate) rise1 = e;
            if (fall0 < 0 && rise0 >= 0 && !gate) fall0 = e;
            if (rise0 < 0 && gate) rise0 = e;
            if (done0 < 0 && sample_done) done0 = e;
            if (e == 27) begin
                chk("t1_hz0", 64'(hz_out[HW-1:0]), 64'd100);
                chk("t1_valid", 64'(valid), 64'b001);
            end
        end
        chk("t1_rise_edge", 64'(rise0), 64'd5);
        chk("t1_gate_len", 64'(fall0 - rise0), 64'd20);
        chk("t1_done_lag", 64'(done0 - fall0), 64'd2);
        chk("t2_period", 64'(rise1 - rise0), 64'd27);
        chk("t2_hz_bank", 64'(hz_out), 64'({10'd120, 10'd110, 10'd100}));
        chk("t2_valid", 64'(valid), 64'b111);
        chk("t2_sel_wrap", 64'(sel), 64'd0);

        // Mic routing, then abort mid-gate of channel 1.
        do_reset();
        mic_in = '0;
        enable = 1'b1;
        for (int e = 0; e <= 40; e++) begin
            prev = mic_in[1];
            tick();
            if (e >= 2 && e <= 26) chk("t5_mic_sel0", 64'(mic_out), 64'd0);
            if (e >= 29) chk("t5_mic_sel1", 64'(mic_out), 64'(prev));
            mic_in[1] = ~mic_in[1];
        end
        enable = 1'b0;
        tick();
        chk("t3_gate_drop", 64'(gate), 64'd0);
        dn = 0;
        repeat (30) begin
            tick();
            if (sample_done) dn++;
        end
        chk("t3_no_capture", 64'(dn), 64'd0);
        chk("t3_valid_kept", 64'(valid), 64'b001);
        chk("t3_hz_kept", 64'(hz_out[HW-1:0]), 64'd100);
        enable = 1'b1;
        tick();
        chk("t3_restart_sel", 64'(sel), 64'd0);

        // Reset mid-gate.
        repeat (9) tick();
        chk("t4_gate_high", 64'(gate), 64'd1);
        reset = 1'b1;
        tick();
        chk("t4_gate", 64'(gate), 64'd0);
        chk("t4_mic", 64'(mic_out), 64'd0);
        chk("t4_sel", 64'(sel), 64'd0);
        chk("t4_hz", 64'(hz_out), 64'd0);
        chk("t4_valid", 64'(valid), 64'd0);
        chk("t4_done", 64'(sample_done), 64'd0);
        reset = 1'b0; enable = 1'b0;
        tick();

        // Disable sampled on the capture edge: capture still lands.
        do_reset();
        enable = 1'b1;
        for (int e = 0; e <= 26; e++) tick();
        enable = 1'b0;
        tick();
        chk("t7_done", 64'(sample_done), 64'd1);
        chk("t7_valid", 64'(valid), 64'b001);
        repeat (6) tick();
        chk("t7_idle_gate", 64'(gate), 64'd0);

        // Loudest-channel selection with a tie.
        do_reset();
        hz_mode = 2;
        enable = 1'b1;
        for (int e = 0; e <= 3 * PER + 1; e++) tick();
        chk("t6_hz_bank", 64'(hz_out), 64'({10'd130, 10'd130, 10'd100}));
`ifdef MIC_SCHED_BEST_EN
        chk("t6_best_ch", 64'(best_ch), 64'd1);
        chk("t6_best_valid", 64'(best_valid), 64'd1);
`else
        chk("t6_best_ch", 64'(best_ch), 64'd0);
        chk("t6_best_valid", 64'(best_valid), 64'd0);
`endif

        // Randomised run against the model.
        hz_mode = 0;
        enable = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            mic_in = N'($urandom);
            if (enable) begin
                if ($urandom_range(0, 199) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) enable = 1'b1;
            end
            reset = ($urandom_range(0, 1499) == 0);
        end
        reset = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
